hosc_seq: RTL and testbench

//  Sequencer for NCH high-speed oscillators, running on the always-on low-speed clock.
//  Per channel: on a request, drives the active-low oscillator enable HENB.

---
 rtl/hosc_seq_pkg.sv | 15 +
 rtl/hosc_seq_chan.sv | 80 ++++++++
 rtl/hosc_seq.sv | 51 +++++
 tb/tb_hosc_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hosc_seq_pkg.sv
// Shared definitions for the oscillator sequencer: channel state encodings
// and the legality check for the cool-down length.
package hosc_seq_pkg;

   localparam logic [1:0] ST_OFF  = 2'b00;
   localparam logic [1:0] ST_WARM = 2'b01;
   localparam logic [1:0] ST_RDY  = 2'b10;
   localparam logic [1:0] ST_COOL = 2'b11;

   // Cool-down must be at least one cycle and must fit the shared counter.
   function automatic bit off_min_ok(input longint off_min, input longint wu_w);
      return (off_min >= 1) && (off_min < (longint'(1) << wu_w));
   endfunction

endpackage

// File: rtl/hosc_seq_chan.sv
// One oscillator channel: OFF/WARM/RDY/COOL sequencer with a shared
// warm-up / cool-down down-counter and registered HENB, rdy, rdy_pulse.
module hosc_seq_chan
   import hosc_seq_pkg::*;
#(
   parameter int unsigned WU_W    = 16,
   parameter int unsigned OFF_MIN = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic [WU_W-1:0] wu_cycles_i,
   output logic            henb_o,
   output logic            rdy_o,
   output logic            rdy_pulse_o,
   output logic            rdy_nxt_o
);

   localparam logic [WU_W-1:0] OFF_LD = WU_W'(OFF_MIN);

   logic [1:0]      state_q, state_d;
   logic [WU_W-1:0] cnt_q, cnt_d;
   logic            henb_q, rdy_q, rdy_pulse_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_OFF: begin
            if (req_i) begin
               state_d = ST_WARM;
               cnt_d   = wu_cycles_i;
            end
         end
         ST_WARM: begin
            // A release beats warm-up completion so abort always gets a full cool-down.
            if (!req_i) begin
               state_d = ST_COOL;
               cnt_d   = OFF_LD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = ST_RDY;
            end
         end
         ST_RDY: begin
            if (!req_i) begin
               state_d = ST_COOL;
               cnt_d   = OFF_LD;
            end
         end
         default: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             state_d = ST_OFF;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         henb_q      <= 1'b1;
         rdy_q       <= 1'b0;
         rdy_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         henb_q      <= !((state_d == ST_WARM) || (state_d == ST_RDY));
         rdy_q       <= (state_d == ST_RDY);
         rdy_pulse_q <= (state_d == ST_RDY) && !rdy_q;
      end
   end

   assign henb_o      = henb_q;
   assign rdy_o       = rdy_q;
   assign rdy_pulse_o = rdy_pulse_q;
   assign rdy_nxt_o   = (state_d == ST_RDY);

endmodule

// File: rtl/hosc_seq.sv
// High-speed oscillator sequencer: NCH independent channels on the
// always-on LCLK plus a registered all-ready flag.
module hosc_seq
   import hosc_seq_pkg::*;
#(
   parameter int unsigned NCH     = 2,
   parameter int unsigned WU_W    = 16,
   parameter int unsigned OFF_MIN = 3
) (
   input  logic                LCLK,
   input  logic                RESET,
   input  logic [NCH-1:0]      req,
   input  logic [NCH*WU_W-1:0] wu_cycles,
   output logic [NCH-1:0]      HENB,
   output logic [NCH-1:0]      rdy,
   output logic [NCH-1:0]      rdy_pulse,
   output logic                all_rdy
);

   if (!off_min_ok(OFF_MIN, WU_W)) begin : g_bad_off_min
      $error("hosc_seq: OFF_MIN out of range for WU_W");
   end

   logic [NCH-1:0] rdy_d;
   logic           all_rdy_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      hosc_seq_chan #(
         .WU_W    (WU_W),
         .OFF_MIN (OFF_MIN)
      ) u_chan (
         .clk_i       (LCLK),
         .rst_i       (RESET),
         .req_i       (req[i]),
         .wu_cycles_i (wu_cycles[i*WU_W +: WU_W]),
         .henb_o      (HENB[i]),
         .rdy_o       (rdy[i]),
         .rdy_pulse_o (rdy_pulse[i]),
         .rdy_nxt_o   (rdy_d[i])
      );
   end

   // Built from next-state rdy so it rises on the same edge as the last channel.
   always_ff @(posedge LCLK or posedge RESET) begin
      if (RESET) all_rdy_q <= 1'b0;
      else       all_rdy_q <= &rdy_d;
   end

   assign all_rdy = all_rdy_q;

endmodule

// File: tb/tb_hosc_seq.sv
// Self-checking bench for hosc_seq (NCH=2, WU_W=4, OFF_MIN=3): vector table,
// hand-written corner sequences and random traffic against a timestamp model.
module tb_hosc_seq;

   localparam int NCH     = 2;
   localparam int WU_W    = 4;
   localparam int OFF_MIN = 3;

   logic                LCLK = 1'b0;
   logic                RESET = 1'b1;
   logic [NCH-1:0]      req = '0;
   logic [NCH*WU_W-1:0] wu_cycles = '0;
   logic [NCH-1:0]      HENB, rdy, rdy_pulse;
   logic                all_rdy;

   hosc_seq #(.NCH(NCH), .WU_W(WU_W), .OFF_MIN(OFF_MIN)) dut (
      .LCLK      (LCLK),
      .RESET     (RESET),
      .req       (req),
      .wu_cycles (wu_cycles),
      .HENB      (HENB),
      .rdy       (rdy),
      .rdy_pulse (rdy_pulse),
      .all_rdy   (all_rdy)
   );

   always #5 LCLK = ~LCLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: each channel is running or not; when it started we know the edge
   // at which it becomes ready, and when it released we know the first edge
   // at which a new request may be accepted.
   int       cyc = 0;
   bit       run [NCH];
   int       rdy_at [NCH];
   int       avail [NCH];
   bit       prev_rdy [NCH];
   logic [NCH-1:0] m_henb, m_rdy, m_pls;
   logic     m_all;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         run[i] = 0; rdy_at[i] = 0; avail[i] = 0; prev_rdy[i] = 0;
      end
      m_henb = '1; m_rdy = '0; m_pls = '0; m_all = 1'b0;
   endtask

   task automatic model_edge(input logic [NCH-1:0] r, input logic [NCH*WU_W-1:0] w);
      cyc++;
      for (int i = 0; i < NCH; i++) begin
         if (!run[i] && cyc >= avail[i] && r[i]) begin
            run[i]    = 1;
            rdy_at[i] = cyc + int'(w[i*WU_W +: WU_W]) + 1;
         end else if (run[i] && !r[i]) begin
            run[i]   = 0;
            avail[i] = cyc + OFF_MIN + 2;
         end
         m_henb[i]   = !run[i];
         m_rdy[i]    = run[i] && (cyc >= rdy_at[i]);
         m_pls[i]    = m_rdy[i] && !prev_rdy[i];
         prev_rdy[i] = m_rdy[i];
      end
      m_all = &m_rdy;
   endtask

   task automatic step(input logic [NCH-1:0] r, input logic [NCH*WU_W-1:0] w);
      @(negedge LCLK);
      req = r;
      wu_cycles = w;
      @(posedge LCLK);
      model_edge(r, w);
      #1;
      chk("m_henb", 8'(HENB), 8'(m_henb));
      chk("m_rdy", 8'(rdy), 8'(m_rdy));
      chk("m_pulse", 8'(rdy_pulse), 8'(m_pls));
      chk("m_all", 8'(all_rdy), 8'(m_all));
   endtask

   typedef struct {
      logic [1:0] req;
      logic [7:0] wu;
      logic [1:0] henb;
      logic [1:0] rdy;
      logic [1:0] pls;
      logic       all;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, k0, k1, ka;
      logic [1:0] r;

      // {req, {wu1,wu0}, HENB, rdy, rdy_pulse, all_rdy}
      tbl[0]  = '{2'b01, 8'h02, 2'b10, 2'b00, 2'b00, 1'b0};
      tbl[1]  = '{2'b11, 8'h02, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[2]  = '{2'b11, 8'h02, 2'b00, 2'b10, 2'b10, 1'b0};
      tbl[3]  = '{2'b11, 8'h02, 2'b00, 2'b11, 2'b01, 1'b1};
      tbl[4]  = '{2'b11, 8'h02, 2'b00, 2'b11, 2'b00, 1'b1};
      tbl[5]  = '{2'b10, 8'h02, 2'b01, 2'b10, 2'b00, 1'b0};
      tbl[6]  = '{2'b11, 8'h02, 2'b01, 2'b10, 2'b00, 1'b0};
      tbl[7]  = '{2'b11, 8'h02, 2'b01, 2'b10, 2'b00, 1'b0};
      tbl[8]  = '{2'b11, 8'h02, 2'b01, 2'b10, 2'b00, 1'b0};
      tbl[9]  = '{2'b11, 8'h02, 2'b01, 2'b10, 2'b00, 1'b0};
      tbl[10] = '{2'b11, 8'h00, 2'b00, 2'b10, 2'b00, 1'b0};
      tbl[11] = '{2'b11, 8'h00, 2'b00, 2'b11, 2'b01, 1'b1};
      tbl[12] = '{2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 1'b0};

      // Reset with random requests: outputs must sit at their reset values.
      model_reset();
      req = 2'($urandom);
      wu_cycles = 8'($urandom);
      repeat (2) @(posedge LCLK);
      #1;
      chk("rst_henb", 8'(HENB), 8'h03);
      chk("rst_rdy", 8'(rdy), 8'h00);
      chk("rst_pulse", 8'(rdy_pulse), 8'h00);
      chk("rst_all", 8'(all_rdy), 8'h00);
      req = '0;
      RESET = 1'b0;

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].req, tbl[i].wu);
         chk($sformatf("tbl%0d_henb", i), 8'(HENB), 8'(tbl[i].henb));
         chk($sformatf("tbl%0d_rdy", i), 8'(rdy), 8'(tbl[i].rdy));
         chk($sformatf("tbl%0d_pulse", i), 8'(rdy_pulse), 8'(tbl[i].pls));
         chk($sformatf("tbl%0d_all", i), 8'(all_rdy), 8'(tbl[i].all));
      end
      repeat (6) step(2'b00, 8'h00);

      // Full-length warm-up; wu changes after the start must be ignored.
      step(2'b01, 8'h0F);
      chk("max_henb_fall", 8'(HENB[0]), 8'h00);
      n = 0;
      while (n < 40) begin
         step(2'b01, 8'h00);
         n++;
         if (rdy[0]) break;
      end
      chk("max_wu_cycles", 8'(n), 8'd16);
      step(2'b00, 8'h00);
      repeat (5) step(2'b00, 8'h00);

      // Abort mid-warm-up, re-request at once: HENB high for OFF_MIN+2 cycles.
      repeat (3) step(2'b01, 8'h0A);
      step(2'b00, 8'h00);
      n = HENB[0] ? 1 : 0;
      while (n < 20) begin
         step(2'b01, 8'h04);
         if (HENB[0]) n++;
         else break;
      end
      chk("abort_henb_high", 8'(n), 8'd5);
      n = 0;
      while (n < 20) begin
         step(2'b01, 8'h00);
         n++;
         if (rdy[0]) break;
      end
      chk("rewarm_cycles", 8'(n), 8'd5);
      step(2'b00, 8'h00);
      repeat (6) step(2'b00, 8'h00);

      // Two channels with wu={7,2} started together.
      k0 = 0; k1 = 0; ka = 0;
      for (k = 1; k <= 12; k++) begin
         step(2'b11, 8'h72);
         if (rdy[0] && k0 == 0) k0 = k;
         if (rdy[1] && k1 == 0) k1 = k;
         if (all_rdy && ka == 0) ka = k;
      end
      chk("multi_rdy0_edge", 8'(k0), 8'd4);
      chk("multi_rdy1_edge", 8'(k1), 8'd9);
      chk("multi_all_edge", 8'(ka), 8'd9);
      step(2'b10, 8'h72);
      chk("multi_all_drop", 8'(all_rdy), 8'h00);
      chk("multi_rdy_drop", 8'(rdy), 8'h02);

      // Asynchronous reset between edges while ch1 is ready.
      #1 RESET = 1'b1;
      #1;
      chk("arst_henb", 8'(HENB), 8'h03);
      chk("arst_rdy", 8'(rdy), 8'h00);
      chk("arst_all", 8'(all_rdy), 8'h00);
      model_reset();
      #1 RESET = 1'b0;
      step(2'b10, 8'h10);
      chk("arst_restart_henb", 8'(HENB), 8'h01);
      step(2'b10, 8'h10);
      step(2'b10, 8'h10);
      chk("arst_restart_rdy", 8'(rdy), 8'h02);

      // Random traffic against the model.
      r = 2'b00;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(3) == 0) r[c] = ~r[c];
         step(r, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
